// File: rtl/hazard_stall_ctrl.sv
`timescale 1ns/1ps
// hazard_stall_ctrl
// Stall/bubble controller for the five-stage pipeline.
// - Register hazards: Tuse/Tnew comparison of the D operands against the
//   pending writes in E and M.
// - MDU hazards: a busy sequencer covers the multi-cycle mult/div unit.
// Optional feature macro: MDU_STALL_EN.
// - Defined: the busy sequencer and stall_md are built.
// - Undefined: busy is tied low, and start_E, div_E and md_D are ignored.
module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [1:0] tuse_rs_D,
   input  logic [1:0] tuse_rt_D,
   input  logic       md_D,
   input  logic [4:0] A3_E,
   input  logic [1:0] tnew_E,
   input  logic [4:0] A3_M,
   input  logic [1:0] tnew_M,
   input  logic       start_E,
   input  logic       div_E,
   output logic       stall,
   output logic       PC_WE,
   output logic       FD_WE,
   output logic       DE_clr,
   output logic       busy
);

   logic stall_rs;
   logic stall_rt;
   logic stall_md;

   // Register dependencies that forwarding cannot cover. Register 0 never stalls.
   always_comb begin
      stall_rs = (rs_D != 5'd0) &
                 (((rs_D == A3_E) & (tnew_E > tuse_rs_D)) |
                  ((rs_D == A3_M) & (tnew_M > tuse_rs_D)));
      stall_rt = (rt_D != 5'd0) &
                 (((rt_D == A3_E) & (tnew_E > tuse_rt_D)) |
                  ((rt_D == A3_M) & (tnew_M > tuse_rt_D)));
   end

`ifdef MDU_STALL_EN
   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   // Sequencer registers. Reset is asynchronous, so a reset in the middle of
   // an operation drops busy at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. The issue cycle itself counts as busy, so only
   // CYCLES-1 cycles are loaded. A start seen while BUSY is ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start_E) begin
               cnt_d   = div_E ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q > 4'd1) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               cnt_d   = 4'd0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // busy covers the issue cycle plus the BUSY state. It is forced low
   // while reset is held.
   always_comb begin
      busy     = ~reset & ((state_q == BUSY) | start_E);
      stall_md = md_D & busy;
   end
`else
   // No MDU tracking. The sequencer inputs are collected here only so that
   // they are not left dangling.
   logic unused_mdu;
   always_comb begin
      unused_mdu = ^{clk, reset, start_E, div_E, md_D};
      busy       = 1'b0;
      stall_md   = 1'b0;
   end
`endif

   // Combine the stall sources. Freeze PC and F/D, and bubble D/E, all in the
   // same cycle.
   always_comb begin
      stall  = stall_rs | stall_rt | stall_md;
      PC_WE  = ~stall;
      FD_WE  = ~stall;
      DE_clr = stall;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Central stall and bubble controller for the five-stage pipeline. Each cycle it compares the register-read demands of the instruction in D against the pending writes in E and M, using Tuse/Tnew, and tracks the multi-cycle multiply/divide unit with a busy sequencer. From these it drives the write enables of the PC and the F/D pipeline register and the clear of the D/E register. It holds F and D frozen and injects a bubble into E whenever forwarding cannot cover a dependency.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after issue from E (≥2)
- DIV_CYCLES, 10, busy cycles for div/divu after issue from E (≥2)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; forces sequencer to IDLE
- rs_D  in  5  rs field of instruction in D
- rt_D  in  5  rt field of instruction in D
- tuse_rs_D  in  2  cycles until D instr needs rs (3 = not used)
- tuse_rt_D  in  2  cycles until D instr needs rt (3 = not used)
- md_D  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- A3_E  in  5  destination register of instr in E (0 = none)
- tnew_E  in  2  cycles until E result is available, relative to E
- A3_M  in  5  destination register of instr in M
- tnew_M  in  2  cycles until M result is available, relative to M
- start_E  in  1  mult/div instr is in E this cycle
- div_E  in  1  with start_E: 1 = div/divu, 0 = mult/multu
- stall  out  1  pipeline stall this cycle
- PC_WE  out  1  PC write enable
- FD_WE  out  1  F/D register write enable
- DE_clr  out  1  synchronous clear of the D/E register (bubble)
- busy  out  1  MDU occupied

## Operation
- Register stall: stall_rs = (rs_D≠0) & [(rs_D==A3_E & tnew_E>tuse_rs_D) | (rs_D==A3_M & tnew_M>tuse_rs_D)]; stall_rt is the same expression using rt_D and tuse_rt_D. Comparisons are 2-bit unsigned. Writes to register 0 never stall.
- MDU sequencer states: IDLE, BUSY; 4-bit down-counter cnt.
  - IDLE & start_E: cnt ← (div_E ? DIV_CYCLES : MULT_CYCLES) − 1, go to BUSY.
  - BUSY & cnt>1: cnt ← cnt−1.
  - BUSY & cnt==1: cnt ← 0, go to IDLE.
  - BUSY & start_E: start is ignored and the current count continues.
- busy = (state==BUSY) | start_E.
- stall_md = md_D & busy.
- stall = stall_rs | stall_rt | stall_md; PC_WE = FD_WE = ~stall; DE_clr = stall.
- All outputs are combinational from inputs and state; the only registers are state and cnt.

## Timing
- While reset is high: state=IDLE, cnt=0, busy=0, stall_md=0. stall is reset-independent through stall_rs and stall_rt only.
- Reset asserted mid-BUSY returns to IDLE immediately, without waiting for clk.
- A stall takes effect in the same cycle it is detected. The D instr is held and E receives a NOP at the next edge.
- A mult issued in E at edge N drives busy high in cycles N through N+MULT_CYCLES−1 (busy counts as start cycle plus MULT_CYCLES−1 BUSY cycles). busy is low from cycle N+MULT_CYCLES.
- An md_D instr waiting on busy is released in the first cycle busy=0.
- When register and MDU stalls occur together, a single stall is asserted; no extra bubble is added.

## Configuration
- MDU_STALL_EN defined: the sequencer, the busy output and stall_md are built as described.
- MDU_STALL_EN undefined: no state or counter is built; busy is tied to 0, stall = stall_rs | stall_rt, and start_E, div_E and md_D are ignored.

## Test plan
- rs_D=5, A3_E=5, tnew_E=2, tuse_rs_D=0 -> stall=1, PC_WE=0, FD_WE=0, DE_clr=1. With A3_E=0 and rs_D=0 -> stall=0.
- rt_D=8, A3_M=8, tnew_M=1, tuse_rt_D=0 -> stall=1. Same inputs with tuse_rt_D=1 -> stall=0.
- start_E=1, div_E=0 for one cycle, md_D=1 held -> busy=1 and stall=1 for exactly 5 cycles, then stall=0.
- start_E=1, div_E=1, md_D=0 -> busy=1 for 10 cycles and stall=0 throughout.
- Div started; reset pulsed high for 1 ns at cycle 3 between edges -> busy=0 immediately, state IDLE, and the next start_E restarts the full count.
- MDU_STALL_EN undefined; start_E=1, md_D=1 -> busy=0 and stall=0.
